// File: rtl/branch_unit.sv
// Branch-control unit: owns the N/Z flag register, the jump-target LUT and a
// circular return-address stack, and drives the program counter's branch controls.
module branch_unit #(
    parameter int D        = 12,
    parameter int LUT_AW   = 5,
    parameter int RS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [D-1:0]      progCtr,
    input  logic              instValid,
    input  logic [2:0]        brOp,
    input  logic              brFlagSel,
    input  logic              brInvert,
    input  logic [LUT_AW-1:0] brIdx,
    input  logic              aluFlagWe,
    input  logic              aluNgtv,
    input  logic              aluZero,
    input  logic              lutWe,
    input  logic [LUT_AW-1:0] lutWaddr,
    input  logic [D-1:0]      lutWdata,
    output logic              ctrlBranchFlag,
    output logic              ctrlBranchInvert,
    output logic              ctrlRelBranch,
    output logic              ctrlAbsBranch,
    output logic              flagNgtv,
    output logic              flagZero,
    output logic [D-1:0]      target,
    output logic              rsOverflow,
    output logic              rsUnderflow
);

    localparam int LUT_N = 1 << LUT_AW;
    localparam int RS_PW = $clog2(RS_DEPTH);
    localparam int RS_CW = $clog2(RS_DEPTH + 1);

    localparam logic [2:0] OP_CREL = 3'd1;
    localparam logic [2:0] OP_CABS = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_JMP  = 3'd5;

    logic             flag_n;
    logic             flag_z;
    logic [D-1:0]     lut [LUT_N];
    logic [D-1:0]     stack [RS_DEPTH];
    logic [RS_PW-1:0] sp;
    logic [RS_CW-1:0] count;
    logic             overflow;
    logic             underflow;

    logic             is_crel;
    logic             is_cabs;
    logic             is_call;
    logic             is_ret;
    logic             is_jmp;
    logic             stack_empty;
    logic             stack_full;
    logic [RS_PW-1:0] top_idx;
    logic [D-1:0]     top_data;
    logic [D-1:0]     lut_rd;
    logic [D-1:0]     ret_addr;

    // ---- decode ----
    always_comb begin
        is_crel     = instValid && (brOp == OP_CREL);
        is_cabs     = instValid && (brOp == OP_CABS);
        is_call     = instValid && (brOp == OP_CALL);
        is_ret      = instValid && (brOp == OP_RET);
        is_jmp      = instValid && (brOp == OP_JMP);
        stack_empty = (count == '0);
        stack_full  = (count == RS_CW'(RS_DEPTH));
        top_idx     = sp - RS_PW'(1);
        top_data    = stack[top_idx];
        lut_rd      = lut[brIdx];
        ret_addr    = progCtr + D'(1);
    end

    // ---- branch controls to the PC (zero latency) ----
    // Unconditional ops select Z and invert with ~Z so the PC's condition is always 1.
    always_comb begin
        ctrlRelBranch    = 1'b0;
        ctrlAbsBranch    = 1'b0;
        ctrlBranchFlag   = 1'b0;
        ctrlBranchInvert = 1'b0;
        target           = lut_rd;
        flagNgtv         = flag_n;
        flagZero         = flag_z;
        rsOverflow       = overflow;
        rsUnderflow      = underflow;
        if (is_crel || is_cabs) begin
            ctrlRelBranch    = is_crel;
            ctrlAbsBranch    = is_cabs;
            ctrlBranchFlag   = brFlagSel;
            ctrlBranchInvert = brInvert;
        end else if (is_call || is_ret || is_jmp) begin
            ctrlAbsBranch    = 1'b1;
            ctrlBranchInvert = ~flag_z;
            if (is_ret) begin
                target = stack_empty ? '0 : top_data;
            end
        end
        if (!reset) begin
            ctrlRelBranch    = 1'b0;
            ctrlAbsBranch    = 1'b0;
            ctrlBranchFlag   = 1'b0;
            ctrlBranchInvert = 1'b0;
            target           = '0;
            flagNgtv         = 1'b0;
            flagZero         = 1'b0;
            rsOverflow       = 1'b0;
            rsUnderflow      = 1'b0;
        end
    end

    // ---- flag register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else if (aluFlagWe) begin
            flag_n <= aluNgtv;
            flag_z <= aluZero;
        end
    end

    // ---- target LUT ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LUT_N; i++) begin
                lut[i] <= '0;
            end
        end else if (lutWe) begin
            lut[lutWaddr] <= lutWdata;
        end
    end

    // ---- return stack ----
    // sp is the next write slot; when full it points at the oldest entry, so a push
    // there overwrites it and the buffer rolls over without moving data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                stack[i] <= '0;
            end
            sp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (is_call) begin
            stack[sp] <= ret_addr;
            sp        <= sp + RS_PW'(1);
            if (stack_full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + RS_CW'(1);
            end
        end else if (is_ret) begin
            if (stack_empty) begin
                underflow <= 1'b1;
            end else begin
                sp    <= top_idx;
                count <= count - RS_CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a queue-based reference model predicts the
// combinational outputs of every cycle, which are compared on the falling edge.
module tb_branch_unit;

    localparam int D        = 12;
    localparam int LUT_AW   = 5;
    localparam int RS_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [D-1:0]      progCtr;
    logic              instValid;
    logic [2:0]        brOp;
    logic              brFlagSel;
    logic              brInvert;
    logic [LUT_AW-1:0] brIdx;
    logic              aluFlagWe;
    logic              aluNgtv;
    logic              aluZero;
    logic              lutWe;
    logic [LUT_AW-1:0] lutWaddr;
    logic [D-1:0]      lutWdata;
    logic              ctrlBranchFlag;
    logic              ctrlBranchInvert;
    logic              ctrlRelBranch;
    logic              ctrlAbsBranch;
    logic              flagNgtv;
    logic              flagZero;
    logic [D-1:0]      target;
    logic              rsOverflow;
    logic              rsUnderflow;

    branch_unit #(.D(D), .LUT_AW(LUT_AW), .RS_DEPTH(RS_DEPTH)) dut (
        .clk(clk), .reset(reset), .progCtr(progCtr), .instValid(instValid),
        .brOp(brOp), .brFlagSel(brFlagSel), .brInvert(brInvert), .brIdx(brIdx),
        .aluFlagWe(aluFlagWe), .aluNgtv(aluNgtv), .aluZero(aluZero),
        .lutWe(lutWe), .lutWaddr(lutWaddr), .lutWdata(lutWdata),
        .ctrlBranchFlag(ctrlBranchFlag), .ctrlBranchInvert(ctrlBranchInvert),
        .ctrlRelBranch(ctrlRelBranch), .ctrlAbsBranch(ctrlAbsBranch),
        .flagNgtv(flagNgtv), .flagZero(flagZero), .target(target),
        .rsOverflow(rsOverflow), .rsUnderflow(rsUnderflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rel;
        logic         abs_br;
        logic         flg;
        logic         inv;
        logic         fn;
        logic         fz;
        logic         ovf;
        logic         unf;
        logic         taken;
        logic [D-1:0] tgt;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_errors = 0;
    string        tag;

    logic         m_n, m_z, m_ovf, m_unf;
    logic [D-1:0] m_lut [1 << LUT_AW];
    logic [D-1:0] m_stk[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle();
        instValid = 1'b0; brOp = 3'd0; brFlagSel = 1'b0; brInvert = 1'b0; brIdx = '0;
        aluFlagWe = 1'b0; aluNgtv = 1'b0; aluZero = 1'b0;
        lutWe = 1'b0; lutWaddr = '0; lutWdata = '0;
    endtask

    task automatic br(input logic [2:0] op, input logic sel, input logic inv,
                      input logic [LUT_AW-1:0] idx, input logic [D-1:0] pc);
        instValid = 1'b1; brOp = op; brFlagSel = sel; brInvert = inv; brIdx = idx; progCtr = pc;
    endtask

    function automatic exp_t predict();
        exp_t e;
        e = '0;
        if (!reset) return e;
        e.fn  = m_n;
        e.fz  = m_z;
        e.ovf = m_ovf;
        e.unf = m_unf;
        e.tgt = m_lut[brIdx];
        if (instValid && (brOp == 3'd1 || brOp == 3'd2)) begin
            e.rel    = (brOp == 3'd1);
            e.abs_br = (brOp == 3'd2);
            e.flg    = brFlagSel;
            e.inv    = brInvert;
        end else if (instValid && (brOp == 3'd3 || brOp == 3'd4 || brOp == 3'd5)) begin
            e.abs_br = 1'b1;
            e.inv    = ~m_z;
            if (brOp == 3'd4) e.tgt = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size() - 1];
        end
        e.taken = (e.rel | e.abs_br) & ((e.flg ? m_n : m_z) ^ e.inv);
        return e;
    endfunction

    task automatic update_model();
        if (!reset) begin
            m_n = 1'b0; m_z = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            for (int i = 0; i < (1 << LUT_AW); i++) m_lut[i] = '0;
            m_stk.delete();
            return;
        end
        if (instValid && brOp == 3'd3) begin
            if (m_stk.size() == RS_DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            m_stk.push_back(progCtr + 12'd1);
        end else if (instValid && brOp == 3'd4) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else void'(m_stk.pop_back());
        end
        if (aluFlagWe) begin
            m_n = aluNgtv;
            m_z = aluZero;
        end
        if (lutWe) m_lut[lutWaddr] = lutWdata;
    endtask

    // One clock: predict, compare mid-cycle, advance the model across the edge.
    task automatic step(input string name);
        exp_t e;
        logic tk;
        tag = name;
        sb.push_back(predict());
        @(negedge clk);
        e  = sb.pop_front();
        tk = (ctrlRelBranch | ctrlAbsBranch) &
             ((ctrlBranchFlag ? flagNgtv : flagZero) ^ ctrlBranchInvert);
        check({tag, ".rel"},   32'(ctrlRelBranch),    32'(e.rel));
        check({tag, ".abs"},   32'(ctrlAbsBranch),    32'(e.abs_br));
        check({tag, ".flg"},   32'(ctrlBranchFlag),   32'(e.flg));
        check({tag, ".inv"},   32'(ctrlBranchInvert), 32'(e.inv));
        check({tag, ".N"},     32'(flagNgtv),         32'(e.fn));
        check({tag, ".Z"},     32'(flagZero),         32'(e.fz));
        check({tag, ".tgt"},   32'(target),           32'(e.tgt));
        check({tag, ".ovf"},   32'(rsOverflow),       32'(e.ovf));
        check({tag, ".unf"},   32'(rsUnderflow),      32'(e.unf));
        check({tag, ".taken"}, 32'(tk),               32'(e.taken));
        update_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        progCtr = '0;
        reset   = 1'b0;
        m_n = 1'b0; m_z = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < (1 << LUT_AW); i++) m_lut[i] = '0;

        br(3'd3, 1'b0, 1'b0, 5'd3, 12'h123);
        step("reset0");
        step("reset1");
        reset = 1'b1;
        idle();

        // Program LUT and set Z=1
        lutWe = 1'b1; lutWaddr = 5'd3; lutWdata = 12'h010;
        aluFlagWe = 1'b1; aluZero = 1'b1;
        step("lut3");
        idle(); lutWe = 1'b1; lutWaddr = 5'd1; lutWdata = 12'h200;
        step("lut1");
        idle();

        br(3'd1, 1'b0, 1'b0, 5'd3, 12'h040);
        step("crel_z1");
        check("crel_z1_target_const", 32'(m_lut[3]), 32'h010);
        idle(); aluFlagWe = 1'b1; aluZero = 1'b0;
        step("setz0");
        idle(); br(3'd1, 1'b0, 1'b0, 5'd3, 12'h041);
        step("crel_z0");
        br(3'd1, 1'b0, 1'b1, 5'd3, 12'h042);
        step("crel_z0_inv");

        // Same-cycle flag write uses old N
        idle(); br(3'd2, 1'b1, 1'b0, 5'd3, 12'h050);
        aluFlagWe = 1'b1; aluNgtv = 1'b1;
        step("hazard_old_n");
        idle(); br(3'd2, 1'b1, 1'b0, 5'd3, 12'h051);
        step("hazard_new_n");

        // Same-cycle LUT write returns old entry
        idle(); br(3'd5, 1'b0, 1'b0, 5'd5, 12'h060);
        lutWe = 1'b1; lutWaddr = 5'd5; lutWdata = 12'h0AB;
        step("lut_rd_old");
        idle(); br(3'd5, 1'b0, 1'b0, 5'd5, 12'h061);
        step("lut_rd_new");

        // Call at PC wrap, ret, then ret on empty
        br(3'd3, 1'b0, 1'b0, 5'd1, 12'hFFF);
        step("call_fff");
        br(3'd4, 1'b0, 1'b0, 5'd0, 12'h200);
        step("ret_wrap");
        br(3'd4, 1'b0, 1'b0, 5'd0, 12'h201);
        step("ret_empty");
        idle();
        step("unf_sticky");

        // Overflow: five calls, four returns
        for (int i = 0; i < 5; i++) begin
            br(3'd3, 1'b0, 1'b0, 5'd1, 12'h010 + 12'(i));
            step($sformatf("call%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            br(3'd4, 1'b0, 1'b0, 5'd0, 12'h300);
            step($sformatf("ret%0d", i));
        end
        idle(); br(3'd3, 1'b0, 1'b0, 5'd1, 12'h400); instValid = 1'b0;
        step("call_invalid");

        // Randomised mix including undefined ops 6/7
        for (int i = 0; i < 40; i++) begin
            idle();
            br(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), 12'($urandom));
            instValid = ($urandom_range(0, 3) != 0);
            aluFlagWe = 1'($urandom); aluNgtv = 1'($urandom); aluZero = 1'($urandom);
            lutWe = 1'($urandom); lutWaddr = 5'($urandom_range(0, 7)); lutWdata = 12'($urandom);
            step($sformatf("rnd%0d", i));
        end

        // Reset with two entries on the stack
        idle(); br(3'd3, 1'b0, 1'b0, 5'd1, 12'h0A0);
        step("pre_rst_call0");
        br(3'd3, 1'b0, 1'b0, 5'd1, 12'h0A1);
        step("pre_rst_call1");
        br(3'd4, 1'b1, 1'b1, 5'd1, 12'h0A2);
        aluFlagWe = 1'b1; aluNgtv = 1'b1; aluZero = 1'b1;
        reset = 1'b0;
        step("mid_reset");
        reset = 1'b1;
        idle(); br(3'd4, 1'b0, 1'b0, 5'd1, 12'h0A3);
        step("post_rst_ret");
        idle();
        step("post_rst_unf");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
